shift_reg_ctrl: RTL and testbench
=================================

SHIFT_REG_CTRL -- requirements
Module: shift_reg_ctrl

Interface
REQ-001 Parameter: WIDTH, 8, number of bits in the controlled Hamming-protected universal register, and the shift count per transfer.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  reset, asynchronous and active-low.
REQ-004 Port: req_tx  input  1  requester A wants to serialize tx_data through the register in PISO mode.
REQ-005 Port: tx_data  input  WIDTH  byte to serialize, sampled on the grant edge.
REQ-006 Port: gnt_tx  output  1  one-cycle accept pulse for requester A.
REQ-007 Port: req_rx  input  1  requester B wants to deserialize WIDTH bits in SIPO mode.
REQ-008 Port: gnt_rx  output  1  one-cycle accept pulse for requester B.
REQ-009 Port: rx_data  output  WIDTH  captured parallel result of the last RX transfer.
REQ-010 Port: done  output  1  one-cycle transfer-complete pulse.
REQ-011 Port: err  output  1  valid with done; 1 = Hamming error flagged during the transfer.
REQ-012 Port: busy  output  1  high in every state except IDLE.
REQ-013 Port: reg_enable / reg_load  output  1 each  drive the register's enable and load inputs.
REQ-014 Port: reg_mode  output  2  drives the register mode: 00 SISO, 01 SIPO, 10 PISO, 11 PIPO.
REQ-015 Port: reg_parallel_in  output  WIDTH  drives the register's parallel input.
REQ-016 Port: reg_parallel_out  input  WIDTH  the register's corrected parallel output.
REQ-017 Port: reg_err  input  1  the register's Hamming error-detect flag.

Function
REQ-018 FSM states: IDLE, LOAD, SHIFT, CAPTURE, DONE; all outputs registered.
REQ-019 IDLE: reg_enable=0, reg_load=0, reg_mode=00, so the register holds its contents.
REQ-020 IDLE grant rules:
- If exactly one request is high at an edge, that requester is granted.
- If both are high, round-robin applies: the requester not granted last wins.
- The pointer resets to favour TX.
REQ-021 TX grant edge: tx_data is latched into a holding register, state goes to LOAD, and gnt_tx=1 for that one cycle.
REQ-022 LOAD (1 cycle): reg_mode=10, reg_load=1, reg_enable=1, reg_parallel_in = held byte; then SHIFT.
REQ-023 TX SHIFT:
- Lasts exactly WIDTH cycles with reg_mode=10, reg_enable=1, reg_load=0.
- A counter runs 0..WIDTH-1; at count WIDTH-1 the state goes to DONE.
REQ-024 RX grant edge: state goes to SHIFT, gnt_rx=1 for that cycle, and reg_mode=01, reg_enable=1 for WIDTH cycles; then CAPTURE.
REQ-025 CAPTURE (1 cycle): reg_enable=0, and rx_data is loaded from reg_parallel_out at the end of the cycle; then DONE.
REQ-026 DONE (1 cycle): done=1 and err valid, then IDLE; no new grant is issued in the DONE cycle.
REQ-027 Latency, counted from the grant edge:
- TX: done is high in cycle WIDTH+1 (grant edge = cycle 0).
- RX: done is high in cycle WIDTH+1.
REQ-028 Error capture: a sticky flag is set if reg_err=1 on any edge in LOAD, SHIFT or CAPTURE; it is cleared on each grant edge and presented on err during DONE.
REQ-029 Request behaviour outside IDLE: requests are ignored while busy=1. A requester may drop req before it is granted without side effects.
REQ-030 rx_data holds its value until the next CAPTURE; TX transfers do not change it.
REQ-031 gnt_tx and gnt_rx are never both high; done and a grant are never high in the same cycle.

Reset
REQ-032 When rst=0 (asynchronously), and for as long as it is held:
- state=IDLE and counter=0.
- All outputs are 0: gnt_tx, gnt_rx, done, err, busy, reg_enable, reg_load, reg_mode, reg_parallel_in, rx_data.
- The RR pointer selects TX.
REQ-033 Reset mid-transfer abandons the transfer with no done pulse. After release, the first edge with a request follows REQ-020.

Verification
REQ-034 TX only: req_tx=1, tx_data=8'hDB -> gnt_tx in cycle 0; LOAD drives reg_parallel_in=8'hDB with reg_load=1; 8 cycles with mode=10; done=1, err=0 in cycle 9.
REQ-035 RX only: req_rx=1, with a register model shifting in 1,0,0,0,1,0,0,0 -> 8 cycles with mode=01; done in cycle 9; rx_data equals the model's parallel_out (e.g. 8'h11).
REQ-036 Contention: req_tx=req_rx=1 held -> grants alternate TX, RX, TX; each grant follows the previous done by at least one cycle.
REQ-037 Error: force reg_err=1 for one cycle mid-SHIFT -> done with err=1; the next clean transfer gives err=0.
REQ-038 Reset mid-SHIFT: assert rst=0 at shift count 4 -> all outputs 0 immediately, no done pulse; after release, req_tx is granted normally.

Source files
------------

// File: rtl/shift_reg_ctrl.sv
// Transfer controller for a Hamming-protected universal shift register.
// Arbitrates a TX (PISO) and an RX (SIPO) requester; all outputs are registered.
module shift_reg_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_tx,
  input  logic [WIDTH-1:0] tx_data,
  output logic             gnt_tx,
  input  logic             req_rx,
  output logic             gnt_rx,
  output logic [WIDTH-1:0] rx_data,
  output logic             done,
  output logic             err,
  output logic             busy,
  output logic             reg_enable,
  output logic             reg_load,
  output logic [1:0]       reg_mode,
  output logic [WIDTH-1:0] reg_parallel_in,
  input  logic [WIDTH-1:0] reg_parallel_out,
  input  logic             reg_err
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  localparam logic [1:0] ModeHold = 2'b00;
  localparam logic [1:0] ModeSipo = 2'b01;
  localparam logic [1:0] ModePiso = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StShift,
    StCapture,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             is_rx_q, is_rx_d;
  logic             prio_rx_q, prio_rx_d;
  logic             err_flag_q, err_flag_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             grant_tx, grant_rx;
  logic             in_xfer;

  logic             gnt_tx_d, gnt_rx_d, done_d, err_d, busy_d;
  logic             reg_enable_d, reg_load_d;
  logic [1:0]       reg_mode_d;
  logic [WIDTH-1:0] reg_parallel_in_d, rx_data_d;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      is_rx_q    <= 1'b0;
      prio_rx_q  <= 1'b0;
      err_flag_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_rx_q    <= is_rx_d;
      prio_rx_q  <= prio_rx_d;
      err_flag_q <= err_flag_d;
      hold_q     <= hold_d;
    end
  end

  assign in_xfer = (state_q == StLoad) || (state_q == StShift) || (state_q == StCapture);

  // Next-state logic, including arbitration and the sticky error flag
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    grant_tx  = 1'b0;
    grant_rx  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // On contention the requester not granted last wins
        if (req_tx && (!req_rx || !prio_rx_q)) begin
          grant_tx = 1'b1;
          state_d  = StLoad;
        end else if (req_rx) begin
          grant_rx = 1'b1;
          state_d  = StShift;
          cnt_d    = '0;
        end
      end
      StLoad: begin
        state_d = StShift;
        cnt_d   = '0;
      end
      StShift: begin
        if (cnt_q == CntLast) begin
          state_d = is_rx_q ? StCapture : StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StCapture: state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase

    is_rx_d   = grant_rx ? 1'b1 : (grant_tx ? 1'b0 : is_rx_q);
    prio_rx_d = grant_tx ? 1'b1 : (grant_rx ? 1'b0 : prio_rx_q);
    hold_d    = grant_tx ? tx_data : hold_q;

    if (grant_tx || grant_rx) begin
      err_flag_d = 1'b0;
    end else if (in_xfer && reg_err) begin
      err_flag_d = 1'b1;
    end else begin
      err_flag_d = err_flag_q;
    end
  end

  // Output decode from the next state so every output lands in a flop
  always_comb begin
    gnt_tx_d          = grant_tx;
    gnt_rx_d          = grant_rx;
    busy_d            = (state_d != StIdle);
    done_d            = (state_d == StDone);
    err_d             = (state_d == StDone) && err_flag_d;
    reg_enable_d      = 1'b0;
    reg_load_d        = 1'b0;
    reg_mode_d        = ModeHold;
    reg_parallel_in_d = '0;
    rx_data_d         = (state_q == StCapture) ? reg_parallel_out : rx_data;
    unique case (state_d)
      StLoad: begin
        reg_enable_d      = 1'b1;
        reg_load_d        = 1'b1;
        reg_mode_d        = ModePiso;
        reg_parallel_in_d = hold_d;
      end
      StShift: begin
        reg_enable_d = 1'b1;
        reg_mode_d   = is_rx_d ? ModeSipo : ModePiso;
      end
      default: begin
        reg_enable_d = 1'b0;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_tx          <= 1'b0;
      gnt_rx          <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
      busy            <= 1'b0;
      reg_enable      <= 1'b0;
      reg_load        <= 1'b0;
      reg_mode        <= ModeHold;
      reg_parallel_in <= '0;
      rx_data         <= '0;
    end else begin
      gnt_tx          <= gnt_tx_d;
      gnt_rx          <= gnt_rx_d;
      done            <= done_d;
      err             <= err_d;
      busy            <= busy_d;
      reg_enable      <= reg_enable_d;
      reg_load        <= reg_load_d;
      reg_mode        <= reg_mode_d;
      reg_parallel_in <= reg_parallel_in_d;
      rx_data         <= rx_data_d;
    end
  end

  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst) !(gnt_tx && gnt_rx));
  a_done_no_grant: assert property (@(posedge clk) disable iff (!rst)
                                    !(done && (gnt_tx || gnt_rx)));

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Randomized bench for shift_reg_ctrl with a transfer-level reference model
// and a behavioural universal register hooked to the controller outputs.
module tb_shift_reg_ctrl;
  localparam int W  = 8;
  localparam int VW = 9 + 2 * W;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_tx, req_rx, reg_err;
  logic [W-1:0] tx_data;
  logic         gnt_tx, gnt_rx, done, err, busy, reg_enable, reg_load;
  logic [1:0]   reg_mode;
  logic [W-1:0] rx_data, reg_parallel_in, reg_parallel_out;

  always #5 clk = ~clk;

  shift_reg_ctrl #(.WIDTH(W)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_tx           (req_tx),
    .tx_data          (tx_data),
    .gnt_tx           (gnt_tx),
    .req_rx           (req_rx),
    .gnt_rx           (gnt_rx),
    .rx_data          (rx_data),
    .done             (done),
    .err              (err),
    .busy             (busy),
    .reg_enable       (reg_enable),
    .reg_load         (reg_load),
    .reg_mode         (reg_mode),
    .reg_parallel_in  (reg_parallel_in),
    .reg_parallel_out (reg_parallel_out),
    .reg_err          (reg_err)
  );

  // Behavioural register: RX bits enter at the MSB and move right
  logic [W-1:0] reg_q = '0;
  assign reg_parallel_out = reg_q;

  // Transfer-level model: phase -1 = idle, else cycles since the grant edge
  int           phase = -1;
  bit           kind_rx = 1'b0;
  bit           prefer_rx = 1'b0;
  bit           err_acc = 1'b0;
  logic [W-1:0] tx_hold = '0, rx_bits = '0, rx_exp = '0, next_rx_bits = '0;
  logic [VW-1:0] exp_v;
  int           checks = 0, errors = 0, cyc = 0;

  function automatic logic [VW-1:0] obs();
    return {gnt_tx, gnt_rx, done, err, busy, reg_enable, reg_load, reg_mode,
            reg_parallel_in, rx_data};
  endfunction

  function automatic logic [VW-1:0] calc_exp();
    logic g_tx, g_rx, dn, er, bz, en, ld;
    logic [1:0] md;
    logic [W-1:0] pin;
    {g_tx, g_rx, dn, er, bz, en, ld} = '0;
    md  = 2'b00;
    pin = '0;
    if (!rst) return '0;
    if (phase >= 0) begin
      bz   = 1'b1;
      g_tx = (phase == 0) && !kind_rx;
      g_rx = (phase == 0) && kind_rx;
      dn   = (phase == W + 1);
      er   = dn && err_acc;
      if (!kind_rx && phase <= W) begin
        en = 1'b1;
        md = 2'b10;
        ld = (phase == 0);
        if (phase == 0) pin = tx_hold;
      end
      if (kind_rx && phase < W) begin
        en = 1'b1;
        md = 2'b01;
      end
    end
    return {g_tx, g_rx, dn, er, bz, en, ld, md, pin, rx_exp};
  endfunction

  // One clock: model the edge from the current inputs, then settle at the negedge
  task automatic tick();
    logic en, ld, ser;
    logic [1:0] md;
    logic [W-1:0] pin;
    en  = reg_enable;
    ld  = reg_load;
    md  = reg_mode;
    pin = reg_parallel_in;
    ser = (phase >= 0 && kind_rx && phase < W) ? rx_bits[phase] : 1'b0;
    @(posedge clk);
    if (!rst) begin
      phase = -1; prefer_rx = 1'b0; err_acc = 1'b0; rx_exp = '0;
    end else if (phase < 0) begin
      if (req_tx && (!req_rx || !prefer_rx)) begin
        kind_rx = 1'b0; tx_hold = tx_data; phase = 0; prefer_rx = 1'b1; err_acc = 1'b0;
      end else if (req_rx) begin
        kind_rx = 1'b1; rx_bits = next_rx_bits; phase = 0; prefer_rx = 1'b0; err_acc = 1'b0;
      end
    end else if (phase == W + 1) begin
      phase = -1;
    end else begin
      if (reg_err) err_acc = 1'b1;
      if (kind_rx && phase == W) rx_exp = rx_bits;
      phase++;
    end
    @(negedge clk);
    if (en) begin
      if (md == 2'b01) reg_q = {ser, reg_q[W-1:1]};
      else if (md == 2'b10) reg_q = ld ? pin : {1'b0, reg_q[W-1:1]};
      else if (md == 2'b11 && ld) reg_q = pin;
    end
    exp_v = calc_exp();
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_tx = 1'b1; req_rx = 1'b1; tx_data = 8'hA5; reg_err = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs() !== '0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: got %h expected 0", cyc, obs());
      end
    end
    req_tx = 1'b0; req_rx = 1'b0; reg_err = 1'b0;
    rst = 1'b1;
    tick();
    checks++;
    if (obs() !== exp_v) begin
      errors++;
      $display("FAIL reset_idle cycle %0d: got %h expected %h", cyc, obs(), exp_v);
    end
  endtask

  task automatic test_tx_only();
    int g = -1;
    req_tx = 1'b1; tx_data = 8'hDB;
    for (int i = 0; i < W + 5; i++) begin
      tick();
      if (phase >= 0) req_tx = 1'b0;
      checks++;
      if (obs() !== exp_v) begin
        errors++;
        $display("FAIL tx_only cycle %0d: got %h expected %h", cyc, obs(), exp_v);
      end
      if (gnt_tx) g = i;
      if (done) begin
        checks++;
        if (g < 0 || i - g != W + 1 || err !== 1'b0) begin
          errors++;
          $display("FAIL tx_latency: got done at %0d err %b, expected %0d err 0", i - g, err,
                   W + 1);
        end
      end
    end
  endtask

  task automatic test_rx_only();
    int g = -1;
    req_rx = 1'b1; next_rx_bits = 8'h11;
    for (int i = 0; i < W + 5; i++) begin
      tick();
      if (phase >= 0) req_rx = 1'b0;
      checks++;
      if (obs() !== exp_v) begin
        errors++;
        $display("FAIL rx_only cycle %0d: got %h expected %h", cyc, obs(), exp_v);
      end
      if (gnt_rx) g = i;
      if (done) begin
        checks++;
        if (g < 0 || i - g != W + 1 || rx_data !== 8'h11) begin
          errors++;
          $display("FAIL rx_result: got latency %0d data %h, expected %0d data 11", i - g,
                   rx_data, W + 1);
        end
      end
    end
  endtask

  task automatic test_contention();
    int order[$];
    int last_done = -100;
    req_tx = 1'b1; req_rx = 1'b1;
    next_rx_bits = 8'h3C; tx_data = 8'h96;
    for (int i = 0; i < 3 * (W + 3) + 2 + W + 4; i++) begin
      if (i == 3 * (W + 3) + 2) begin req_tx = 1'b0; req_rx = 1'b0; end
      tick();
      checks++;
      if (obs() !== exp_v) begin
        errors++;
        $display("FAIL contention cycle %0d: got %h expected %h", cyc, obs(), exp_v);
      end
      if (gnt_tx || gnt_rx) begin
        order.push_back(gnt_rx ? 1 : 0);
        checks++;
        if (i - last_done < 2) begin
          errors++;
          $display("FAIL grant_gap: got %0d cycles after done, expected >= 2", i - last_done);
        end
      end
      if (done) last_done = i;
    end
    checks++;
    if (order.size() < 3 || order[0] != 0 || order[1] != 1 || order[2] != 0) begin
      errors++;
      $display("FAIL rr_order: got %0d grants %p, expected TX RX TX first", order.size(), order);
    end
  endtask

  task automatic test_error();
    int nd = 0;
    bit errs[2];
    req_tx = 1'b1; tx_data = 8'h5A;
    for (int i = 0; i < 2 * (W + 3) + W + 4; i++) begin
      if (i == 2 * (W + 3)) req_tx = 1'b0;
      reg_err = (nd == 0 && phase == 4);
      tick();
      checks++;
      if (obs() !== exp_v) begin
        errors++;
        $display("FAIL error_flow cycle %0d: got %h expected %h", cyc, obs(), exp_v);
      end
      if (done && nd < 2) begin errs[nd] = err; nd++; end
    end
    reg_err = 1'b0;
    checks++;
    if (nd != 2 || errs[0] !== 1'b1 || errs[1] !== 1'b0) begin
      errors++;
      $display("FAIL err_sticky: got %0d dones err %b/%b, expected 2 dones err 1/0", nd,
               errs[0], errs[1]);
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    req_tx = 1'b1; tx_data = 8'hC3;
    for (int i = 0; i < 20 && phase != 5; i++) tick();
    req_tx = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (obs() !== '0) begin
      errors++;
      $display("FAIL reset_async: got %h expected 0", obs());
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (obs() !== exp_v || done !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: got %h expected %h", cyc, obs(), exp_v);
      end
    end
    rst = 1'b1; req_tx = 1'b1; tx_data = 8'h4E;
    for (int i = 0; i < W + 5; i++) begin
      tick();
      if (phase >= 0) req_tx = 1'b0;
      checks++;
      if (obs() !== exp_v) begin
        errors++;
        $display("FAIL reset_resume cycle %0d: got %h expected %h", cyc, obs(), exp_v);
      end
      if (i == 0) seen = gnt_tx;
    end
    checks++;
    if (seen !== 1'b1) begin
      errors++;
      $display("FAIL resume_grant: got gnt_tx %b on first edge, expected 1", seen);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      req_tx       = ($urandom_range(0, 2) != 0);
      req_rx       = ($urandom_range(0, 2) != 0);
      tx_data      = W'($urandom);
      next_rx_bits = W'($urandom);
      reg_err      = ($urandom_range(0, 11) == 0);
      tick();
      checks++;
      if (obs() !== exp_v) begin
        errors++;
        $display("FAIL random cycle %0d: got %h expected %h", cyc, obs(), exp_v);
      end
    end
    req_tx = 1'b0; req_rx = 1'b0; reg_err = 1'b0;
  endtask

  initial begin
    rst = 1'b0; req_tx = 1'b0; req_rx = 1'b0; reg_err = 1'b0; tx_data = '0;
    exp_v = '0;
    @(negedge clk);
    test_reset();
    test_tx_only();
    test_rx_only();
    test_contention();
    test_error();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
